ieee_div: RTL and testbench
===========================

Name: ieee_div

Overview:
Sequential IEEE-754 binary32 divider. It is the inverse operation to the combinational ieee_mul and produces s = a / b. It uses radix-2 restoring division of the 24-bit significands, one quotient bit per clock, under a start/busy/done handshake. It sits beside ieee_mul in the ALU floating-point path and uses the same truncating (no-rounding), no-denormal number model.

Parameters:
- None. The format is fixed at binary32: 1 sign bit, 8 exponent bits, 23 mantissa bits, bias 127.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  32  dividend; latched on accepted start
- b  in  32  divisor; latched on accepted start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when s and flags update
- s  out  32  quotient
- OVERFLOW  out  1  result exponent too large
- UNDERFLOW  out  1  result exponent too small
- DIVZERO  out  1  divisor exponent field is zero

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy, done, s, OVERFLOW, UNDERFLOW and DIVZERO all go to 0. An operation in flight is aborted with no done pulse. Leaving reset always lands in IDLE.
- FSM has three states: IDLE, DIV and NORM.
  - IDLE: when start=1 at edge k, latch a and b, clear the quotient, load the remainder with {1,a[22:0]}, set cnt=0, set busy=1, go to DIV. start=0 stays in IDLE.
  - DIV: on edges k+1 to k+25, do one restoring step per edge (25 steps total).
    - Trial = remainder - {1,b[22:0]}.
    - If trial >= 0: quotient bit = 1 and remainder = trial<<1.
    - Otherwise: quotient bit = 0 and remainder = remainder<<1.
    - Quotient shifts in MSB-first. The remainder is 26 bits wide.
    - After the step with cnt=24, go to NORM.
  - NORM: on edge k+26, write s and all flags, set done=1 and busy=0, return to IDLE.
- Latency: done is high for exactly one cycle, following the 26th edge after the edge that accepted start. The next start can be accepted in that same done cycle.
- Arithmetic:
  - sign = a[31]^b[31].
  - e = a[30:23] - b[30:23] + 127, computed as a 10-bit signed value.
  - q is the 25-bit value (ma<<24)/mb, truncated.
  - If q[24]=1: mant = q[23:1].
  - Otherwise: mant = q[22:0] and e = e-1.
  - No rounding is performed.
- Result selection, in priority order:
  1. b[30:23]==0: DIVZERO=1, s={sign,8'hFF,23'h0}.
  2. a[30:23]==0: s={sign,31'h0}, no flags set.
  3. e>=255: OVERFLOW=1, s={sign,8'hFF,23'h0}.
  4. e<=0: UNDERFLOW=1, s={sign,31'h0}.
  5. Otherwise: s={sign,e[7:0],mant}, flags 0.
  - Exactly one flag, or none, is set per result.
  - Special cases still take the full 26-edge latency.
- Hold rules:
  - s and the flags hold their values until the next done; they do not change during busy.
  - start while busy is ignored; no queuing.
  - a and b may change freely after the accepting edge.
  - Inf/NaN encodings in the operands are not decoded. They pass through the arithmetic like any other encoding.

Test Plan:
- a=0x40C00000 (6.0), b=0x40000000 (2.0), start pulse → done exactly 26 edges later, s=0x40400000, all flags 0, busy high for 26 cycles.
- a=0x3F800000 (1.0), b=0x40400000 (3.0) → s=0x3EAAAAAA. This covers truncation and the q[24]=0 normalisation path.
- a=0xC0C00000, b=0x40000000 → s=0xC0400000. Then a=0x3F800000, b=0x00000000 → s=0x7F800000 and DIVZERO=1.
- a=0x7F000000, b=0x00800000 → OVERFLOW=1, s=0x7F800000. Then a=0x00800000, b=0x7F000000 → UNDERFLOW=1, s=0x00000000.
- Start 6.0/2.0, then assert start with a new a/b at cycle 10 → the second request is ignored and s=0x40400000. A new start during the done cycle is accepted and its result arrives 26 edges later.
- Assert rst_n=0 at cycle 12 of an operation → busy, s and flags go to 0 immediately and no done pulse occurs. A subsequent fresh start completes normally.

Source files
------------

// File: rtl/ieee_div.sv
// ieee_div: sequential IEEE-754 binary32 divider, s = a / b.
// Radix-2 restoring division of the 24-bit significands, one quotient bit
// per clock. Truncating (no rounding), no denormals; Inf/NaN are not decoded.
//
// Handshake: start is sampled only while idle. The accepting edge latches
// a and b and raises busy. After 25 divide steps and one normalise step,
// s and the flags update together with a one-cycle done pulse, and busy
// drops in that same cycle. A start presented during the done cycle is
// accepted. A start presented while busy is dropped, not queued.
module ieee_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] s,
  output logic        OVERFLOW,
  output logic        UNDERFLOW,
  output logic        DIVZERO
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2
  } state_e;

  // Index of the final divide step; 25 steps produce a 25-bit quotient.
  localparam logic [4:0] LAST_STEP = 5'd24;

  state_e      state_q, state_d;

  // Operand fields captured on the accepting edge.
  logic        sign_q, sign_d;
  logic [7:0]  ea_q, ea_d;
  logic [7:0]  eb_q, eb_d;
  logic [23:0] mb_q, mb_d;

  // Divider datapath.
  logic [25:0] rem_q, rem_d;
  logic [24:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;

  // Registered outputs.
  logic [31:0] s_q, s_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic        dz_q, dz_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Restoring step signals.
  logic [25:0] rem_sub;
  logic        take;

  // Result assembly signals.
  logic signed [9:0] e_raw;
  logic signed [9:0] e_fin;
  logic [22:0]       mant;
  logic [31:0]       res_s;
  logic              res_ovf;
  logic              res_unf;
  logic              res_dz;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> DIV on start, 25 DIV steps, one NORM step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DIV;
      DIV:     if (cnt_q == LAST_STEP) state_d = NORM;
      NORM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One restoring step: subtract the divisor when it fits, then shift left.
  // When the subtract succeeds the difference is below mb, so the shift
  // cannot lose a set bit.
  always_comb begin
    take    = (rem_q >= {2'b00, mb_q});
    rem_sub = rem_q - {2'b00, mb_q};
  end

  // Exponent, mantissa normalisation and special-case selection from the
  // finished quotient. The quotient lies in [2^23, 2^25): bit 24 set means
  // the significand ratio was >= 1, otherwise shift one place and borrow
  // one from the exponent.
  always_comb begin
    e_raw = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + 10'sd127;
    if (quo_q[24]) begin
      e_fin = e_raw;
      mant  = quo_q[23:1];
    end else begin
      e_fin = e_raw - 10'sd1;
      mant  = quo_q[22:0];
    end

    res_s   = {sign_q, 31'h0};
    res_ovf = 1'b0;
    res_unf = 1'b0;
    res_dz  = 1'b0;
    if (eb_q == 8'h00) begin
      res_dz = 1'b1;
      res_s  = {sign_q, 8'hFF, 23'h0};
    end else if (ea_q == 8'h00) begin
      res_s = {sign_q, 31'h0};
    end else if (e_fin >= 10'sd255) begin
      res_ovf = 1'b1;
      res_s   = {sign_q, 8'hFF, 23'h0};
    end else if (e_fin <= 10'sd0) begin
      res_unf = 1'b1;
      res_s   = {sign_q, 31'h0};
    end else begin
      res_s = {sign_q, e_fin[7:0], mant};
    end
  end

  // Per-state datapath and output next values; outputs hold outside NORM.
  always_comb begin
    sign_d = sign_q;
    ea_d   = ea_q;
    eb_d   = eb_q;
    mb_d   = mb_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    s_d    = s_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    dz_d   = dz_q;
    busy_d = busy_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d = a[31] ^ b[31];
          ea_d   = a[30:23];
          eb_d   = b[30:23];
          mb_d   = {1'b1, b[22:0]};
          rem_d  = {2'b01, a[22:0]};
          quo_d  = 25'd0;
          cnt_d  = 5'd0;
          busy_d = 1'b1;
        end
      end
      DIV: begin
        rem_d = (take ? rem_sub : rem_q) << 1;
        quo_d = {quo_q[23:0], take};
        cnt_d = cnt_q + 5'd1;
      end
      NORM: begin
        s_d    = res_s;
        ovf_d  = res_ovf;
        unf_d  = res_unf;
        dz_d   = res_dz;
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
      ea_q   <= 8'h00;
      eb_q   <= 8'h00;
      mb_q   <= 24'h0;
      rem_q  <= 26'h0;
      quo_q  <= 25'h0;
      cnt_q  <= 5'd0;
      s_q    <= 32'h0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      dz_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sign_q <= sign_d;
      ea_q   <= ea_d;
      eb_q   <= eb_d;
      mb_q   <= mb_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      s_q    <= s_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      dz_q   <= dz_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign s         = s_q;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = unf_q;
  assign DIVZERO   = dz_q;

endmodule

// File: tb/tb_ieee_div.sv
// tb_ieee_div: directed bench for ieee_div with a behavioural reference
// model and a per-cycle output comparison.
module tb_ieee_div;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] s;
  logic        OVERFLOW, UNDERFLOW, DIVZERO;

  always #5 clk = ~clk;

  ieee_div dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .s         (s),
    .OVERFLOW  (OVERFLOW),
    .UNDERFLOW (UNDERFLOW),
    .DIVZERO   (DIVZERO)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  // Returns {DIVZERO, OVERFLOW, UNDERFLOW, s} from plain integer arithmetic.
  function automatic logic [34:0] model_div(input logic [31:0] xa, input logic [31:0] xb);
    logic              sgn;
    int                ea, eb, e;
    longint unsigned   ma, mb, q;
    logic [22:0]       mant;
    logic [34:0]       r;
    sgn  = xa[31] ^ xb[31];
    ea   = {24'd0, xa[30:23]};
    eb   = {24'd0, xb[30:23]};
    ma   = 64'h800000 + {41'd0, xa[22:0]};
    mb   = 64'h800000 + {41'd0, xb[22:0]};
    q    = (ma << 24) / mb;
    e    = ea - eb + 127;
    if (q >= 64'd16777216) begin
      mant = 23'((q >> 1) & 64'h7FFFFF);
    end else begin
      mant = 23'(q & 64'h7FFFFF);
      e    = e - 1;
    end
    if (eb == 0)        r = {3'b100, sgn, 8'hFF, 23'h0};
    else if (ea == 0)   r = {3'b000, sgn, 31'h0};
    else if (e >= 255)  r = {3'b010, sgn, 8'hFF, 23'h0};
    else if (e <= 0)    r = {3'b001, sgn, 31'h0};
    else                r = {3'b000, sgn, e[7:0], mant};
    return r;
  endfunction

  // Timing model: an accepted request keeps the unit busy for 26 edges;
  // the edge that brings the countdown to zero publishes the result.
  logic [34:0] exp_q[$];
  logic [34:0] m_res;
  logic [31:0] m_s     = 32'h0;
  logic [2:0]  m_flags = 3'b000;
  logic        m_busy  = 1'b0;
  logic        m_done  = 1'b0;
  int          m_cnt   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   = 0;
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_s     = 32'h0;
      m_flags = 3'b000;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      if (m_cnt == 0) begin
        if (start) begin
          exp_q.push_back(model_div(a, b));
          m_cnt = 26;
        end
      end else begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_res   = exp_q.pop_front();
          m_flags = m_res[34:32];
          m_s     = m_res[31:0];
          m_done  = 1'b1;
        end
      end
      m_busy = (m_cnt != 0);
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    n_checks++;
    if ({busy, done, DIVZERO, OVERFLOW, UNDERFLOW, s} !==
        {m_busy, m_done, m_flags, m_s}) begin
      n_fail++;
      $display("FAIL cycle_compare t=%0t got busy=%b done=%b dz/ovf/unf=%b s=%h exp busy=%b done=%b dz/ovf/unf=%b s=%h",
               $time, busy, done, {DIVZERO, OVERFLOW, UNDERFLOW}, s,
               m_busy, m_done, m_flags, m_s);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, expv);
    end
  endtask

  // Present start for one edge, then wait (bounded) for done.
  // lat counts negedges after the request; done is due at 27.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
      end
      if (busy) busy_cnt++;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  // Call at a negedge. Checks the model and the DUT against literals.
  task automatic do_op(input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] exp_s, input logic [2:0] exp_f,
                       input string name);
    int lat, bc;
    check({"model_", name}, 64'(model_div(xa, xb)), 64'({exp_f, exp_s}));
    start = 1'b1;
    a     = xa;
    b     = xb;
    wait_done(lat, bc);
    check({"latency_", name}, 64'(lat), 64'd27);
    check({"busy_cycles_", name}, 64'(bc), 64'd26);
    check({"s_", name}, 64'(s), 64'(exp_s));
    check({"flags_", name}, 64'({DIVZERO, OVERFLOW, UNDERFLOW}), 64'(exp_f));
  endtask

  // ---------------- directed vectors ----------------
  // exp flags are {DIVZERO, OVERFLOW, UNDERFLOW}.
  logic [31:0] va[16], vb[16], vs[16];
  logic [2:0]  vf[16];

  initial begin
    va[0]  = 32'h40C00000; vb[0]  = 32'h40000000; vs[0]  = 32'h40400000; vf[0]  = 3'b000;
    va[1]  = 32'h3F800000; vb[1]  = 32'h40400000; vs[1]  = 32'h3EAAAAAA; vf[1]  = 3'b000;
    va[2]  = 32'hC0C00000; vb[2]  = 32'h40000000; vs[2]  = 32'hC0400000; vf[2]  = 3'b000;
    va[3]  = 32'h3F800000; vb[3]  = 32'h00000000; vs[3]  = 32'h7F800000; vf[3]  = 3'b100;
    va[4]  = 32'h7F000000; vb[4]  = 32'h00800000; vs[4]  = 32'h7F800000; vf[4]  = 3'b010;
    va[5]  = 32'h00800000; vb[5]  = 32'h7F000000; vs[5]  = 32'h00000000; vf[5]  = 3'b001;
    va[6]  = 32'h00000000; vb[6]  = 32'h40000000; vs[6]  = 32'h00000000; vf[6]  = 3'b000;
    va[7]  = 32'h80000000; vb[7]  = 32'h40000000; vs[7]  = 32'h80000000; vf[7]  = 3'b000;
    va[8]  = 32'h00000000; vb[8]  = 32'h00000000; vs[8]  = 32'h7F800000; vf[8]  = 3'b100;
    va[9]  = 32'h7F7FFFFF; vb[9]  = 32'h3F800000; vs[9]  = 32'h7F7FFFFF; vf[9]  = 3'b000;
    va[10] = 32'h7F000000; vb[10] = 32'h3F000000; vs[10] = 32'h7F800000; vf[10] = 3'b010;
    va[11] = 32'h00800000; vb[11] = 32'h3F800000; vs[11] = 32'h00800000; vf[11] = 3'b000;
    va[12] = 32'h00800000; vb[12] = 32'h40000000; vs[12] = 32'h00000000; vf[12] = 3'b001;
    va[13] = 32'h01000000; vb[13] = 32'h3FC00000; vs[13] = 32'h00AAAAAA; vf[13] = 3'b000;
    va[14] = 32'h00800000; vb[14] = 32'h3FC00000; vs[14] = 32'h00000000; vf[14] = 3'b001;
    va[15] = 32'hC0000000; vb[15] = 32'h00000000; vs[15] = 32'hFF800000; vf[15] = 3'b100;
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, bc;
    bit seen_done;
    rst_n = 1'b0;
    start = 1'b0;
    a     = 32'h0;
    b     = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_state", 64'({busy, done, DIVZERO, OVERFLOW, UNDERFLOW, s}), 64'd0);

    // Main function and boundary vectors.
    for (int i = 0; i < 16; i++) begin
      do_op(va[i], vb[i], vs[i], vf[i], $sformatf("vec%0d", i));
    end

    // A start while busy is ignored; a start in the done cycle is taken.
    start = 1'b1;
    a     = 32'h40C00000;
    b     = 32'h40000000;
    lat   = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 10) begin
        start = 1'b1;
        a     = 32'h7F000000;
        b     = 32'h00800000;
      end
      if (i == 11) start = 1'b0;
      if (done) begin
        lat = i;
        break;
      end
    end
    check("ignored_start_latency", 64'(lat), 64'd27);
    check("ignored_start_s", 64'(s), 64'h40400000);
    check("ignored_start_flags", 64'({DIVZERO, OVERFLOW, UNDERFLOW}), 64'd0);
    start = 1'b1;
    a     = 32'h3F800000;
    b     = 32'h40400000;
    wait_done(lat, bc);
    check("done_cycle_start_latency", 64'(lat), 64'd27);
    check("done_cycle_start_s", 64'(s), 64'h3EAAAAAA);

    // Reset in the middle of an operation aborts it without a done pulse.
    start = 1'b1;
    a     = 32'h7F000000;
    b     = 32'h00800000;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs",
             64'({busy, done, DIVZERO, OVERFLOW, UNDERFLOW, s}), 64'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("no_done_after_abort", 64'(seen_done), 64'd0);
    do_op(32'h40C00000, 32'h40000000, 32'h40400000, 3'b000, "after_reset");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
